i2c_quad_clk_gen: RTL and testbench
===================================

Name: i2c_quad_clk_gen

Overview:
- Fractional-N quadrature clock generator for the I2C datapath.
- From the fast sampling clock it produces a base clock (o_clk0) and a 90-degree-lagging clock (o_clk90), both derived from one shared quarter-period counter.
- Adds runtime-programmable integer and fractional divide, clean start and stop on whole-period boundaries, glitch-free divider reload, and one-hot per-phase strobes.
- Sits between the system clock and the I2C bit engine, which uses o_clk0 as SCL timing and o_clk90 / o_tick to place SDA changes and sample points.

Parameters:
- CNT_WIDTH, 16, width of the quarter-period counter and of i_div_int.
- FRAC_WIDTH, 8, width of the fractional accumulator and of i_div_frac; the fraction equals i_div_frac/2^FRAC_WIDTH.

Ports:
- std_clk  input  1  fast sampling clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- i_enable  input  1  run request, level-sensitive.
- i_div_int  input  CNT_WIDTH  integer std_clk cycles per quarter period; values below 2 are clamped to 2.
- i_div_frac  input  FRAC_WIDTH  fractional cycles per quarter period.
- i_load  input  1  one-cycle strobe that captures i_div_int and i_div_frac.
- o_clk0  output  1  base clock, registered.
- o_clk90  output  1  quadrature clock lagging o_clk0 by one quarter, registered.
- o_tick  output  4  one-hot, one-cycle strobe on the cycle phase k is entered.
- o_busy  output  1  high in RUN and STOP.

Behaviour:
- Interface: one clock, std_clk; reset is synchronous and active-high.
- Reset: on the first std_clk edge with reset=1, all outputs become 0, state=IDLE, counter=0, acc=0, and the active divider becomes int=2, frac=0. Reset is honoured mid-operation with no period completion.
- Phases p=0..3 set the output pair (o_clk0, o_clk90): p0=(1,0), p1=(1,1), p2=(0,1), p3=(0,0). In IDLE the outputs are (0,0).
- States:
  - IDLE: i_enable=1 sampled at edge t gives RUN at t+1 with p=0, o_tick=0001, counter=0, acc=0.
  - RUN: phases advance continuously. i_enable=0 moves to STOP; the phase is unchanged.
  - STOP: identical to RUN, except that completing p3 enters IDLE. i_enable=1 during STOP returns to RUN with no gap or phase jump.
- Quarter length:
  - On every phase entry, including the first, compute {carry, acc_next} = acc + frac_active, with a FRAC_WIDTH+1-bit sum.
  - The quarter lasts int_active + carry cycles; acc is then updated to acc_next.
  - The counter runs from 0 to len-1. On the last count the phase advances (wrapping p3 to p0) and the counter clears.
- o_tick[p] pulses on exactly the cycle that o_clk0/o_clk90 take their new p values. Only one bit is high at a time. All four bits are 0 in IDLE.
- Divider load:
  - i_load in IDLE: the new values become active on the next edge.
  - i_load in RUN or STOP: the values are held pending and applied on the next entry to p0, with acc cleared to 0 at the same entry, so there are no mid-period changes.
  - A second i_load before a pending value is applied overwrites it.
  - If i_load and the p0 entry fall on the same edge, the pending value is the new one, and it is applied at the following p0.
- Clamp: i_div_int of 0 or 1 is treated as 2 at capture.
- Period: 4*int + (number of carries per period). Duty cycle is 50% ±1 cycle.
- Width rules: the counter is CNT_WIDTH bits; len = int + carry must not overflow. int = 2^CNT_WIDTH-1 with carry=1 saturates len at 2^CNT_WIDTH-1.
- Simultaneous events:
  - Reset dominates everything.
  - i_enable falling on the same edge as the p3→p0 transition moves the block to STOP, and the full new period then runs.

Test Plan:
- Reset then i_load int=7, frac=0, i_enable=1: o_clk0 rises one cycle after enable is sampled; o_clk90 rises 7 cycles later; period is 28 cycles; o_tick walks 0001→0010→0100→1000 at 7-cycle spacing.
- int=7, frac=128: quarter lengths 7,8,7,8 repeating, period 30 (400 kHz from 12 MHz); the o_clk90 edge lands 7 cycles after the o_clk0 rise.
- i_enable dropped mid-p1: the period completes through p3, outputs end at (0,0), o_busy falls together with the exit from p3, and no further ticks occur. Re-enabling during STOP causes no gap.
- i_load int=10 while running mid-p2: the current period stays at the old length, new 10-cycle quarters start at the next p0, and the first quarter after the change has no carry.
- i_div_int=1 loaded: behaves as int=2, period 8 cycles.
- reset asserted during p2: outputs are (0,0), o_tick=0, o_busy=0 on the next edge; after release with i_enable held high, a fresh p0 starts one cycle later.

Source files
------------

// File: rtl/i2c_quad_clk_gen.sv
// Fractional-N quadrature clock generator: one quarter-period counter drives a base
// clock, a 90-degree-lagging clock and one-hot per-phase strobes for the I2C bit engine.
module i2c_quad_clk_gen #(
    parameter int CNT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 8
) (
    input  logic                  std_clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic [CNT_WIDTH-1:0]  i_div_int,
    input  logic [FRAC_WIDTH-1:0] i_div_frac,
    input  logic                  i_load,
    output logic                  o_clk0,
    output logic                  o_clk90,
    output logic [3:0]            o_tick,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0]  INT_MIN  = CNT_WIDTH'(2);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [FRAC_WIDTH-1:0] ACC_ZERO = {FRAC_WIDTH{1'b0}};

    function automatic logic [CNT_WIDTH-1:0] clamp_int(input logic [CNT_WIDTH-1:0] v);
        if (v < INT_MIN) begin
            clamp_int = INT_MIN;
        end else begin
            clamp_int = v;
        end
    endfunction

    // Returns {clk0, clk90} for a phase.
    function automatic logic [1:0] phase_pair(input logic [1:0] p);
        case (p)
            2'd0:    phase_pair = 2'b10;
            2'd1:    phase_pair = 2'b11;
            2'd2:    phase_pair = 2'b01;
            2'd3:    phase_pair = 2'b00;
            default: phase_pair = 2'b00;
        endcase
    endfunction

    state_t                state_r, state_s;
    logic [1:0]            phase_r, phase_s;
    logic [CNT_WIDTH-1:0]  cnt_r, cnt_s;
    logic [CNT_WIDTH-1:0]  len_r, len_s;
    logic [FRAC_WIDTH-1:0] acc_r, acc_s;
    logic [CNT_WIDTH-1:0]  int_act_r, int_act_s;
    logic [FRAC_WIDTH-1:0] frac_act_r, frac_act_s;
    logic [CNT_WIDTH-1:0]  int_pend_r, int_pend_s;
    logic [FRAC_WIDTH-1:0] frac_pend_r, frac_pend_s;
    logic                  pend_vld_r, pend_vld_s;
    logic                  clk0_r, clk0_s;
    logic                  clk90_r, clk90_s;
    logic [3:0]            tick_r, tick_s;
    logic                  busy_r, busy_s;

    logic                  last_s;
    logic                  enter_s;
    logic                  wrap_s;
    logic                  exit_s;
    logic [CNT_WIDTH-1:0]  cap_int_s;
    logic                  idle_load_s;
    logic                  pend_cap_s;
    logic                  pend_take_s;
    logic [FRAC_WIDTH-1:0] acc_base_s;
    logic [FRAC_WIDTH:0]   sum_s;
    logic [CNT_WIDTH:0]    len_wide_s;
    logic [1:0]            pair_s;

    assign last_s = (cnt_r == (len_r - CNT_ONE));

    // State, phase and quarter counter sequencing.
    always_comb begin
        state_s = state_r;
        phase_s = phase_r;
        cnt_s   = cnt_r;
        enter_s = 1'b0;
        wrap_s  = 1'b0;
        exit_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                cnt_s   = CNT_ZERO;
                phase_s = 2'd0;
                if (i_enable) begin
                    state_s = ST_RUN;
                    enter_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_STOP: begin
                if (last_s) begin
                    cnt_s = CNT_ZERO;
                    if ((phase_r == 2'd3) && (state_r == ST_STOP) && !i_enable) begin
                        state_s = ST_IDLE;
                        phase_s = 2'd0;
                        exit_s  = 1'b1;
                    end else begin
                        state_s = i_enable ? ST_RUN : ST_STOP;
                        phase_s = phase_r + 2'd1;
                        enter_s = 1'b1;
                        wrap_s  = (phase_r == 2'd3);
                    end
                end else begin
                    cnt_s   = cnt_r + CNT_ONE;
                    state_s = i_enable ? ST_RUN : ST_STOP;
                end
            end
            default: begin
                state_s = ST_IDLE;
                phase_s = 2'd0;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // Divider capture: immediate while idle, otherwise pending until the next p0 entry.
    always_comb begin
        cap_int_s   = clamp_int(i_div_int);
        idle_load_s = i_load && ((state_r == ST_IDLE) || exit_s);
        pend_cap_s  = i_load && !idle_load_s;
        pend_take_s = wrap_s || exit_s;
        int_act_s   = int_act_r;
        frac_act_s  = frac_act_r;
        int_pend_s  = int_pend_r;
        frac_pend_s = frac_pend_r;
        pend_vld_s  = pend_vld_r;
        if (idle_load_s) begin
            int_act_s  = cap_int_s;
            frac_act_s = i_div_frac;
        end else if (pend_take_s && pend_vld_r) begin
            int_act_s  = int_pend_r;
            frac_act_s = frac_pend_r;
        end else begin
            int_act_s  = int_act_r;
            frac_act_s = frac_act_r;
        end
        // A load on the wrap edge itself must survive as the next pending value.
        if (pend_cap_s) begin
            int_pend_s  = cap_int_s;
            frac_pend_s = i_div_frac;
            pend_vld_s  = 1'b1;
        end else if (pend_take_s || idle_load_s) begin
            pend_vld_s  = 1'b0;
        end else begin
            pend_vld_s  = pend_vld_r;
        end
    end

    // Quarter length from the fractional accumulator, saturated to the counter range.
    always_comb begin
        if ((state_r == ST_IDLE) || (wrap_s && pend_vld_r)) begin
            acc_base_s = ACC_ZERO;
        end else begin
            acc_base_s = acc_r;
        end
        sum_s      = {1'b0, acc_base_s} + {1'b0, frac_act_s};
        len_wide_s = {1'b0, int_act_s} + {CNT_ZERO, sum_s[FRAC_WIDTH]};
        if (enter_s) begin
            acc_s = sum_s[FRAC_WIDTH-1:0];
            len_s = len_wide_s[CNT_WIDTH] ? CNT_MAX : len_wide_s[CNT_WIDTH-1:0];
        end else if (exit_s) begin
            acc_s = ACC_ZERO;
            len_s = len_r;
        end else begin
            acc_s = acc_r;
            len_s = len_r;
        end
    end

    // Next values for the registered outputs.
    always_comb begin
        pair_s = phase_pair(phase_s);
        if (state_s != ST_IDLE) begin
            clk0_s  = pair_s[1];
            clk90_s = pair_s[0];
            busy_s  = 1'b1;
        end else begin
            clk0_s  = 1'b0;
            clk90_s = 1'b0;
            busy_s  = 1'b0;
        end
        if (enter_s) begin
            tick_s = 4'b0001 << phase_s;
        end else begin
            tick_s = 4'b0000;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge std_clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            phase_r     <= 2'd0;
            cnt_r       <= CNT_ZERO;
            len_r       <= INT_MIN;
            acc_r       <= ACC_ZERO;
            int_act_r   <= INT_MIN;
            frac_act_r  <= ACC_ZERO;
            int_pend_r  <= INT_MIN;
            frac_pend_r <= ACC_ZERO;
            pend_vld_r  <= 1'b0;
            clk0_r      <= 1'b0;
            clk90_r     <= 1'b0;
            tick_r      <= 4'b0000;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            phase_r     <= phase_s;
            cnt_r       <= cnt_s;
            len_r       <= len_s;
            acc_r       <= acc_s;
            int_act_r   <= int_act_s;
            frac_act_r  <= frac_act_s;
            int_pend_r  <= int_pend_s;
            frac_pend_r <= frac_pend_s;
            pend_vld_r  <= pend_vld_s;
            clk0_r      <= clk0_s;
            clk90_r     <= clk90_s;
            tick_r      <= tick_s;
            busy_r      <= busy_s;
        end
    end

    assign o_clk0  = clk0_r;
    assign o_clk90 = clk90_r;
    assign o_tick  = tick_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_i2c_quad_clk_gen.sv
// Randomized bench for i2c_quad_clk_gen: a quarter-countdown reference model plus
// direct period / quadrature-offset measurements on the output edges.
module tb_i2c_quad_clk_gen;

    localparam int CW      = 5;
    localparam int FW      = 8;
    localparam int LEN_MAX = (1 << CW) - 1;

    logic          std_clk = 1'b0;
    logic          reset;
    logic          i_enable;
    logic [CW-1:0] i_div_int;
    logic [FW-1:0] i_div_frac;
    logic          i_load;
    logic          o_clk0;
    logic          o_clk90;
    logic [3:0]    o_tick;
    logic          o_busy;

    i2c_quad_clk_gen #(.CNT_WIDTH(CW), .FRAC_WIDTH(FW)) dut (
        .std_clk   (std_clk),
        .reset     (reset),
        .i_enable  (i_enable),
        .i_div_int (i_div_int),
        .i_div_frac(i_div_frac),
        .i_load    (i_load),
        .o_clk0    (o_clk0),
        .o_clk90   (o_clk90),
        .o_tick    (o_tick),
        .o_busy    (o_busy)
    );

    always #5 std_clk = ~std_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: running flag, phase, cycles left in the quarter.
    bit m_active, m_stopping, m_pv;
    int m_phase, m_rem, m_acc, m_int, m_frac, m_pint, m_pfrac, m_tick;

    int r0[$];
    int r90[$];
    bit prev0, prev90;

    bit r_en, r_ld, r_rst;
    int r_di, r_df;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic start_quarter();
        int s;
        int len;
        s     = m_acc + m_frac;
        m_acc = s % (1 << FW);
        len   = m_int + ((s >= (1 << FW)) ? 1 : 0);
        if (len > LEN_MAX) len = LEN_MAX;
        m_rem  = len;
        m_tick = 1 << m_phase;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit ld, input int di, input int df);
        int capi;
        bit exit_now;
        capi     = (di < 2) ? 2 : di;
        exit_now = 1'b0;
        m_tick   = 0;
        if (rst) begin
            m_active = 0; m_stopping = 0; m_pv = 0;
            m_phase = 0; m_rem = 0; m_acc = 0; m_int = 2; m_frac = 0;
        end else if (!m_active) begin
            if (ld) begin
                m_int = capi; m_frac = df; m_pv = 0;
            end
            if (en) begin
                m_active = 1; m_stopping = 0; m_phase = 0; m_acc = 0;
                start_quarter();
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                if (m_phase == 3 && m_stopping && !en) begin
                    m_active = 0; m_phase = 0; m_acc = 0; exit_now = 1;
                    if (ld) begin
                        m_int = capi; m_frac = df;
                    end else if (m_pv) begin
                        m_int = m_pint; m_frac = m_pfrac;
                    end
                    m_pv = 0;
                end else begin
                    m_phase = (m_phase + 1) % 4;
                    if (m_phase == 0 && m_pv) begin
                        m_int = m_pint; m_frac = m_pfrac; m_acc = 0; m_pv = 0;
                    end
                    start_quarter();
                end
            end
            if (!exit_now) begin
                if (ld) begin
                    m_pint = capi; m_pfrac = df; m_pv = 1;
                end
                m_stopping = !en;
            end
        end
    endtask

    function automatic int expect_vec();
        int c0, c90;
        if (!m_active) return 0;
        c0  = (m_phase < 2) ? 1 : 0;
        c90 = (m_phase == 1 || m_phase == 2) ? 1 : 0;
        return (c0 << 6) | (c90 << 5) | (m_tick << 1) | 1;
    endfunction

    task automatic step(input bit rst, input bit en, input bit ld, input int di, input int df);
        reset      = rst;
        i_enable   = en;
        i_load     = ld;
        i_div_int  = CW'(di);
        i_div_frac = FW'(df);
        model_step(rst, en, ld, di % (1 << CW), df % (1 << FW));
        @(posedge std_clk);
        #1;
        cyc++;
        check_val("outputs", int'({o_clk0, o_clk90, o_tick, o_busy}), expect_vec());
        if (o_clk0 && !prev0) r0.push_back(cyc);
        if (o_clk90 && !prev90) r90.push_back(cyc);
        prev0  = o_clk0;
        prev90 = o_clk90;
    endtask

    task automatic reset_dut();
        step(1'b1, 1'b0, 1'b0, 0, 0);
        step(1'b1, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic run_until_phase(input int p, input bit en, input int limit);
        for (int k = 0; k < limit; k++) begin
            if (m_active && m_phase == p) return;
            step(1'b0, en, 1'b0, 0, 0);
        end
        check_val("reach_phase", m_phase, p);
    endtask

    task automatic check_period(input string tag, input int exp_period, input int exp_quarter);
        if (r0.size() < 2 || r90.size() < 1) begin
            check_val({tag, "_edges"}, r0.size(), 2);
        end else begin
            check_val({tag, "_period"}, r0[1] - r0[0], exp_period);
            check_val({tag, "_quad"}, r90[0] - r0[0], exp_quarter);
        end
    endtask

    initial begin
        prev0 = 1'b0;
        prev90 = 1'b0;
        reset_dut();
        check_val("reset_busy", int'(o_busy), 0);
        check_val("reset_tick", int'(o_tick), 0);

        // Integer divide 7: 28-cycle period, quadrature edge 7 cycles after clk0 rise.
        step(1'b0, 1'b0, 1'b1, 7, 0);
        r0.delete(); r90.delete();
        repeat (70) step(1'b0, 1'b1, 1'b0, 0, 0);
        check_period("int7", 28, 7);

        // Fractional 7 + 128/256: quarters 7,8,7,8.
        reset_dut();
        step(1'b0, 1'b0, 1'b1, 7, 128);
        r0.delete(); r90.delete();
        repeat (70) step(1'b0, 1'b1, 1'b0, 0, 0);
        check_period("frac7_5", 30, 7);

        // Enable dropped mid-p1: period completes, then idle.
        run_until_phase(1, 1'b1, 100);
        repeat (2) step(1'b0, 1'b1, 1'b0, 0, 0);
        repeat (45) step(1'b0, 1'b0, 1'b0, 0, 0);
        check_val("busy_after_stop", int'(o_busy), 0);

        // Re-enable during STOP: no gap.
        run_until_phase(2, 1'b1, 100);
        repeat (4) step(1'b0, 1'b0, 1'b0, 0, 0);
        repeat (40) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Reload mid-p2: takes effect at the next p0.
        run_until_phase(2, 1'b1, 100);
        step(1'b0, 1'b1, 1'b1, 10, 64);
        repeat (80) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Clamp of 1 to 2: 8-cycle period.
        reset_dut();
        step(1'b0, 1'b0, 1'b1, 1, 0);
        r0.delete(); r90.delete();
        repeat (30) step(1'b0, 1'b1, 1'b0, 0, 0);
        check_period("clamp1", 8, 2);

        // Reset during p2 with enable held high.
        run_until_phase(2, 1'b1, 50);
        step(1'b1, 1'b1, 1'b0, 0, 0);
        check_val("mid_reset_busy", int'(o_busy), 0);
        repeat (10) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Saturation: max int with carry stays at the counter ceiling.
        reset_dut();
        step(1'b0, 1'b0, 1'b1, LEN_MAX, 255);
        repeat (140) step(1'b0, 1'b1, 1'b0, 0, 0);

        // Random traffic.
        r_en = 1'b1;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 39) == 0) r_en = !r_en;
            r_ld  = ($urandom_range(0, 29) == 0);
            r_rst = ($urandom_range(0, 499) == 0);
            r_di  = ($urandom_range(0, 7) == 0) ? LEN_MAX : int'($urandom_range(0, 12));
            r_df  = int'($urandom_range(0, 255));
            step(r_rst, r_en, r_ld, r_di, r_df);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
